// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// optional two's-complement input, sign flag and overflow error pattern.
module bin_to_bcd_seq #(
    parameter int N      = 6,
    parameter int DIGITS = 2,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    function automatic int unsigned dec_digits(input int unsigned n);
        logic [63:0] v;
        int unsigned d;
        v = (64'd1 << n) - 64'd1;
        d = 1;
        while (v > 64'd9) begin
            v = v / 64'd10;
            d++;
        end
        return d;
    endfunction

    function automatic logic [63:0] max_value(input int unsigned d);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < d; i++) v = v * 64'd10;
        return v - 64'd1;
    endfunction

    // Accumulator covers the full N-bit range so no digit is lost before the overflow decision.
    localparam int unsigned ACC_DIGITS = dec_digits(N);
    localparam int unsigned ACCW       = 4 * ACC_DIGITS;
    localparam int unsigned OUTW       = 4 * DIGITS;
    localparam int unsigned EXTW       = (ACCW > OUTW) ? ACCW : OUTW;
    localparam logic [63:0] LIMIT      = max_value(DIGITS);
    localparam int unsigned CW         = $clog2(N + 1);
    localparam logic [CW-1:0] LAST     = CW'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_last;

    logic [ACCW-1:0]   r_acc;
    logic [N-1:0]      r_mag;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_pend;
    logic              r_ovf_pend;
    logic [OUTW-1:0]   r_bcd;
    logic              r_neg;
    logic              r_ovf;
    logic              r_out_valid;

    logic              w_is_neg;
    logic [N-1:0]      w_mag;
    logic              w_ovf;
    logic [ACCW-1:0]   w_acc_adj;
    logic [ACCW-1:0]   w_acc_shift;
    logic [EXTW-1:0]   w_acc_ext;
    logic [OUTW-1:0]   w_bcd_final;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && !rst) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign in_ready = (r_state == S_IDLE) && !rst;

    // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_is_neg = (SIGNED != 0) && bin[N-1];
    assign w_mag    = w_is_neg ? (~bin + N'(1)) : bin;
    assign w_ovf    = {{(64-N){1'b0}}, w_mag} > LIMIT;

    always_comb begin
        w_acc_adj = r_acc;
        for (int unsigned i = 0; i < ACC_DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
        end
    end

    assign w_acc_shift = ACCW'({w_acc_adj, r_mag[N-1]});

    always_comb begin
        w_acc_ext              = '0;
        w_acc_ext[ACCW-1:0]    = w_acc_shift;
        w_bcd_final            = r_ovf_pend ? '1 : OUTW'(w_acc_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_neg_pend  <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_bcd       <= '0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_acc      <= '0;
                r_mag      <= w_mag;
                r_cnt      <= '0;
                r_neg_pend <= w_is_neg;
                r_ovf_pend <= w_ovf;
            end else if (r_state == S_CONV) begin
                r_acc <= w_acc_shift;
                r_mag <= r_mag << 1;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cnt       <= '0;
                    r_bcd       <= w_bcd_final;
                    r_neg       <= r_neg_pend;
                    r_ovf       <= r_ovf_pend;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;
    assign neg       = r_neg;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: three converter configurations driven with directed and
// random words; a negedge monitor checks handshake timing and results.
module tb_bin_to_bcd_seq;

    localparam int NB  = 6;
    localparam int LAT = 6;

    typedef struct packed {
        logic [7:0] bcd;
        logic       neg;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_s [3];
    logic [5:0] bin_s      [3];
    logic       in_ready_s [3];
    logic       out_valid_s[3];
    logic       neg_s      [3];
    logic       ovf_s      [3];
    logic [7:0] bcd_s      [3];
    logic [7:0] bcd0;
    logic [7:0] bcd1;
    logic [3:0] bcd2;

    exp_t q   [3][$];
    exp_t last[3];
    int   busy[3];
    bit   acc_seen[3];
    bit   rst_seen = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.N(6), .DIGITS(2), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .bin(bin_s[0]), .out_valid(out_valid_s[0]), .bcd(bcd0), .neg(neg_s[0]), .ovf(ovf_s[0])
    );
    bin_to_bcd_seq #(.N(6), .DIGITS(2), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .bin(bin_s[1]), .out_valid(out_valid_s[1]), .bcd(bcd1), .neg(neg_s[1]), .ovf(ovf_s[1])
    );
    bin_to_bcd_seq #(.N(6), .DIGITS(1), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .bin(bin_s[2]), .out_valid(out_valid_s[2]), .bcd(bcd2), .neg(neg_s[2]), .ovf(ovf_s[2])
    );

    assign bcd_s[0] = bcd0;
    assign bcd_s[1] = bcd1;
    assign bcd_s[2] = {4'h0, bcd2};

    // Reference: plain integer arithmetic on the configuration of instance k.
    function automatic exp_t model(input int k, input logic [5:0] v);
        exp_t r;
        int   val;
        int   lim;
        bit   sgn;
        sgn   = (k == 1) && v[5];
        val   = sgn ? 64 - int'(v) : int'(v);
        lim   = (k == 2) ? 9 : 99;
        r.neg = sgn;
        r.ovf = (val > lim);
        if (r.ovf) r.bcd = (k == 2) ? 8'h0F : 8'hFF;
        else       r.bcd = 8'((val / 10) * 16 + (val % 10));
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    // Stimulus side: record what the DUT accepted and the expected answer.
    always @(posedge clk) begin
        rst_seen <= rst;
        for (int k = 0; k < 3; k++) begin
            acc_seen[k] <= !rst && in_valid_s[k] && in_ready_s[k];
            if (rst) q[k].delete();
            else if (in_valid_s[k] && in_ready_s[k]) q[k].push_back(model(k, bin_s[k]));
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit exp_ov;
            exp_ov = 1'b0;
            if (rst_seen) begin
                busy[k] = 0;
                last[k] = '0;
            end else begin
                if (busy[k] > 0) begin
                    busy[k]--;
                    exp_ov = (busy[k] == 0);
                end
                if (acc_seen[k]) busy[k] = LAT;
            end
            chk("out_valid", k, 32'(out_valid_s[k]), 32'(exp_ov));
            chk("in_ready", k, 32'(in_ready_s[k]), 32'(!rst && busy[k] == 0));
            if (out_valid_s[k] || exp_ov) begin
                if (q[k].size() != 0) last[k] = q[k].pop_front();
                else chk("result_pending", k, 32'(q[k].size()), 32'd1);
            end
            chk("bcd", k, 32'(bcd_s[k]), 32'(last[k].bcd));
            chk("neg", k, 32'(neg_s[k]), 32'(last[k].neg));
            chk("ovf", k, 32'(ovf_s[k]), 32'(last[k].ovf));
        end
    end

    task automatic send(input int k, input logic [5:0] v, input bit drop);
        bin_s[k]      = v;
        in_valid_s[k] = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready_s[k]) break;
            if (t > 50) begin
                $display("FAIL accept_timeout inst=%0d in_ready=0 required=1", k);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        if (drop) begin
            in_valid_s[k] = 1'b0;
            bin_s[k]      = 6'($urandom);
        end
    endtask

    task automatic wait_idle(input int k);
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (q[k].size() == 0 && in_ready_s[k]) break;
            if (t > 100) begin
                $display("FAIL idle_timeout inst=%0d pending=%0d required=0", k, q[k].size());
                $fatal(1);
            end
        end
    endtask

    task automatic sweep(input int k);
        for (int v = 0; v < 64; v++) begin
            send(k, 6'(v), 1'($urandom_range(0, 1)));
            if (!in_valid_s[k]) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int i = 0; i < 30; i++) begin
            send(k, 6'($urandom), (i == 29) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (!in_valid_s[k]) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid_s[k] = 1'b0;
            bin_s[k]      = '0;
            busy[k]       = 0;
            last[k]       = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 6'd63, 1'b1);
        wait_idle(0);

        send(1, 6'b111101, 1'b1);
        wait_idle(1);
        send(1, 6'b100000, 1'b1);
        wait_idle(1);
        send(1, 6'd31, 1'b1);
        wait_idle(1);

        send(2, 6'd12, 1'b1);
        wait_idle(2);
        send(2, 6'd9, 1'b1);
        wait_idle(2);

        send(0, 6'd5, 1'b0);
        send(0, 6'd17, 1'b1);
        wait_idle(0);

        send(0, 6'd42, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fork
            sweep(0);
            sweep(1);
            sweep(2);
        join
        for (int k = 0; k < 3; k++) wait_idle(k);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
